icache_direct: RTL and testbench
================================

// Module: icache_direct
// PURPOSE
//  Direct-mapped, read-only instruction cache between the IF stage (sram-like cpu_* port) and the
//  AXI bridge's inst port (inst_*). Hits return in 1 cycle. Misses issue one 4-beat line refill
//  (inst_size=3'b100); kseg1 fetches bypass the cache as single-word reads (inst_size=3'b010).
// PARAMETERS
//  INDEX_W     6   log2(line count); 64 lines x 16 B = 1 KiB.
//  UNCACHED_EN 1   1: addr[31:29]==3'b101 bypasses the cache; 0: every fetch is cached.
// PORTS
//  clk          in   1   clock
//  resetn       in   1   reset, synchronous, active-low
//  cpu_req      in   1   fetch request
//  cpu_addr     in   32  fetch address (word aligned; addr[1:0] ignored)
//  cpu_addr_ok  out  1   request accepted this cycle (cpu_req && cpu_addr_ok)
//  cpu_data_ok  out  1   cpu_rdata valid this cycle; 1-cycle pulse per accepted request
//  cpu_rdata    out  32  instruction word
//  flush        in   1   invalidate all lines (1-cycle pulse)
//  inst_req     out  1   memory request; held until inst_rdy
//  inst_size    out  3   3'b100 = 4-word line burst; 3'b010 = single word
//  inst_addr    out  32  line base {addr[31:4],4'b0} or exact uncached word address
//  inst_rdy     in   1   request taken when inst_req && inst_rdy
//  inst_valid   in   1   one returned word per cycle it is high
//  inst_last    in   1   last beat marker (checked by bench only; not used for control)
//  inst_rdata   in   32  returned word
// BEHAVIOUR
//  Reset: state=IDLE, all valid bits 0, beat counter 0; cpu_addr_ok=1, cpu_data_ok=0, inst_req=0.
//  Address split: tag=addr[31:4+INDEX_W], index=addr[4+INDEX_W-1:4], word=addr[3:2].
//  Storage: tag/valid/data arrays in flops, combinational read; valid array reset-cleared.
//  FSM:
//   IDLE   cpu_addr_ok=1. On cpu_req latch addr -> LOOKUP.
//   LOOKUP hit (valid && tag match && !uncached): cpu_data_ok=1, cpu_rdata=data[index][word],
//          cpu_addr_ok=1; a new cpu_req in this cycle is latched -> LOOKUP, else -> IDLE.
//          miss or uncached: cpu_addr_ok=0 -> MISS.
//   MISS   inst_req=1, inst_size/inst_addr per cached/uncached; on inst_rdy -> REFILL, beat cnt=0.
//   REFILL each inst_valid: cached -> write inst_rdata to data[index][cnt], cnt++; word whose
//          cnt==latched word is captured to a return register. After 4th beat (cnt==3) write
//          tag, set valid -> RESP. Uncached: first inst_valid captured -> RESP, no array write.
//   RESP   cpu_data_ok=1, cpu_rdata=return register; cpu_addr_ok=0 -> IDLE.
//  cpu_addr_ok is 0 in MISS, REFILL, RESP and on a LOOKUP miss. Exactly one cpu_data_ok per
//  accepted request, in request order. Miss latency = 2 + arbitration + 4 beats + 1 (RESP).
//  inst_req, inst_addr, inst_size stable from MISS entry until inst_rdy; never asserted elsewhere.
//  inst_valid outside REFILL: ignored (must not corrupt arrays).
//  flush: clears all valid bits next edge in any state. Flush during REFILL: refill still
//   completes and sets its line valid. Flush in the same cycle as a LOOKUP hit: hit still returned.
//  Refill of a line overwrites any previous tag at that index (no writeback; read-only cache).
//  Reset mid-refill: FSM to IDLE, valid cleared; shared resetn also clears the bridge.
// STRUCTURE
//  Package icache_pkg: state encoding (IDLE/LOOKUP/MISS/REFILL/RESP), SIZE_LINE=3'b100,
//   SIZE_WORD=3'b010, KSEG1_TOP=3'b101, line/word width localparams.
//  One sub-module: icache_tag_data_array (tag+valid+4-word data per line, comb read, beat write,
//   valid set/clear-all). FSM and refill counter stay in the top.
// TESTING
//  1 Cold miss: req 0x1FC0_0008 -> inst_req, addr 0x1FC0_0000, size 3'b100; beats
//    A0..A3 -> cpu_data_ok once, cpu_rdata=A2; line 0 valid.
//  2 Back-to-back hits: after T1 req 0x1FC0_0000,..04,..0C every cycle -> cpu_data_ok on 3
//    consecutive cycles with A0,A1,A3; inst_req stays 0.
//  3 Conflict: req 0x1FC0_0408 (same index, new tag) -> refill, returns new word; then
//    0x1FC0_0008 misses again.
//  4 Uncached: req 0xBFC0_0010 -> inst_addr 0xBFC0_0010, size 3'b010, one beat returned;
//    repeat -> misses again (no allocation).
//  5 Flush: flush pulse mid-REFILL of line 0 -> that line valid after refill, all others
//    invalid; flush in IDLE then re-fetch 0x1FC0_0000 -> miss.
//  6 Stall: inst_rdy low 10 cycles, inst_valid gapped -> inst_* held stable, correct word,
//    single cpu_data_ok; resetn low mid-REFILL -> IDLE, cpu_addr_ok=1, all lines invalid.

Source files
------------

// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared types and constants for the direct-mapped instruction cache
package icache_pkg;

  localparam int ADDR_W         = 32;
  localparam int WORD_W         = 32;
  localparam int WORDS_PER_LINE = 4;
  localparam int LINE_OFF_W     = 4;
  localparam int WORD_SEL_W     = 2;

  localparam logic [2:0] SIZE_LINE = 3'b100;
  localparam logic [2:0] SIZE_WORD = 3'b010;
  localparam logic [2:0] KSEG1_TOP = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOOKUP = 3'd1,
    ST_MISS   = 3'd2,
    ST_REFILL = 3'd3,
    ST_RESP   = 3'd4
  } state_t;

  function automatic logic is_kseg1(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1:ADDR_W-3] == KSEG1_TOP;
  endfunction

endpackage

// File: rtl/icache_direct_if.sv
// rtl/icache_direct_if.sv - fetch-side and memory-side bundles of the instruction cache
interface icache_cpu_if;
  logic        cpu_req;
  logic [31:0] cpu_addr;
  logic        cpu_addr_ok;
  logic        cpu_data_ok;
  logic [31:0] cpu_rdata;

  modport master (output cpu_req, cpu_addr, input cpu_addr_ok, cpu_data_ok, cpu_rdata);
  modport slave  (input cpu_req, cpu_addr, output cpu_addr_ok, cpu_data_ok, cpu_rdata);
endinterface

interface icache_mem_if;
  logic        inst_req;
  logic [2:0]  inst_size;
  logic [31:0] inst_addr;
  logic        inst_rdy;
  logic        inst_valid;
  logic        inst_last;
  logic [31:0] inst_rdata;

  modport master (output inst_req, inst_size, inst_addr,
                  input  inst_rdy, inst_valid, inst_last, inst_rdata);
  modport slave  (input  inst_req, inst_size, inst_addr,
                  output inst_rdy, inst_valid, inst_last, inst_rdata);
endinterface

// File: rtl/icache_tag_data_array.sv
// rtl/icache_tag_data_array.sv - tag/valid/data storage with combinational read and per-beat write
module icache_tag_data_array
  import icache_pkg::*;
#(
  parameter int INDEX_W = 6,
  parameter int TAG_W   = 22
) (
  input  logic                              clk,
  input  logic                              resetn,
  input  logic [INDEX_W-1:0]                rd_index,
  output logic                              rd_valid,
  output logic [TAG_W-1:0]                  rd_tag,
  output logic [WORDS_PER_LINE-1:0][WORD_W-1:0] rd_line,
  input  logic                              wr_en,
  input  logic [INDEX_W-1:0]                wr_index,
  input  logic [WORD_SEL_W-1:0]             wr_word,
  input  logic [WORD_W-1:0]                 wr_data,
  input  logic                              set_valid,
  input  logic [TAG_W-1:0]                  set_tag,
  input  logic                              clear_all
);

  localparam int LINES = 1 << INDEX_W;

  logic [LINES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [TAG_W-1:0] tag_d  [LINES];
  logic [WORDS_PER_LINE-1:0][WORD_W-1:0] data_q [LINES];
  logic [WORDS_PER_LINE-1:0][WORD_W-1:0] data_d [LINES];

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_line  = data_q[rd_index];

  // Set is applied after clear so a refill finishing during a flush keeps its line.
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (clear_all) valid_d = '0;
    if (wr_en) data_d[wr_index][wr_word] = wr_data;
    if (set_valid) begin
      valid_d[wr_index] = 1'b1;
      tag_d[wr_index]   = set_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) valid_q <= '0;
    else         valid_q <= valid_d;
  end

  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

endmodule

// File: rtl/icache_direct.sv
// rtl/icache_direct.sv - direct-mapped read-only instruction cache with line refill and kseg1 bypass
module icache_direct
  import icache_pkg::*;
#(
  parameter int INDEX_W     = 6,
  parameter bit UNCACHED_EN = 1'b1
) (
  input  logic         clk,
  input  logic         resetn,
  icache_cpu_if.slave  cpu,
  icache_mem_if.master mem,
  input  logic         flush
);

  localparam int TAG_W = ADDR_W - LINE_OFF_W - INDEX_W;

  state_t                  state_q, state_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [WORD_SEL_W-1:0]   cnt_q, cnt_d;
  logic [WORD_W-1:0]       ret_q, ret_d;

  logic [INDEX_W-1:0]      index;
  logic [TAG_W-1:0]        tag;
  logic [WORD_SEL_W-1:0]   word;
  logic                    uncached;
  logic                    hit;
  logic                    rd_valid;
  logic [TAG_W-1:0]        rd_tag;
  logic [WORDS_PER_LINE-1:0][WORD_W-1:0] rd_line;
  logic                    wr_en;
  logic                    set_valid;
  logic                    unused_bits;

  assign index    = addr_q[LINE_OFF_W+INDEX_W-1:LINE_OFF_W];
  assign tag      = addr_q[ADDR_W-1:LINE_OFF_W+INDEX_W];
  assign word     = addr_q[3:2];
  assign uncached = UNCACHED_EN && is_kseg1(addr_q);
  assign hit      = rd_valid && (rd_tag == tag) && !uncached;

  assign unused_bits = ^{mem.inst_last, addr_q[1:0]};

  assign mem.inst_size = uncached ? SIZE_WORD : SIZE_LINE;
  assign mem.inst_addr = uncached ? {addr_q[ADDR_W-1:2], 2'b00}
                                  : {addr_q[ADDR_W-1:LINE_OFF_W], {LINE_OFF_W{1'b0}}};

  icache_tag_data_array #(
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W)
  ) u_array (
    .clk       (clk),
    .resetn    (resetn),
    .rd_index  (index),
    .rd_valid  (rd_valid),
    .rd_tag    (rd_tag),
    .rd_line   (rd_line),
    .wr_en     (wr_en),
    .wr_index  (index),
    .wr_word   (cnt_q),
    .wr_data   (mem.inst_rdata),
    .set_valid (set_valid),
    .set_tag   (tag),
    .clear_all (flush)
  );

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    cnt_d           = cnt_q;
    ret_d           = ret_q;
    cpu.cpu_addr_ok = 1'b0;
    cpu.cpu_data_ok = 1'b0;
    cpu.cpu_rdata   = ret_q;
    mem.inst_req    = 1'b0;
    wr_en           = 1'b0;
    set_valid       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cpu.cpu_addr_ok = 1'b1;
        if (cpu.cpu_req) begin
          addr_d  = cpu.cpu_addr;
          state_d = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        if (hit) begin
          cpu.cpu_data_ok = 1'b1;
          cpu.cpu_rdata   = rd_line[word];
          cpu.cpu_addr_ok = 1'b1;
          if (cpu.cpu_req) begin
            addr_d  = cpu.cpu_addr;
            state_d = ST_LOOKUP;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_MISS;
        end
      end
      ST_MISS: begin
        mem.inst_req = 1'b1;
        if (mem.inst_rdy) begin
          state_d = ST_REFILL;
          cnt_d   = '0;
        end
      end
      ST_REFILL: begin
        if (mem.inst_valid) begin
          if (uncached) begin
            ret_d   = mem.inst_rdata;
            state_d = ST_RESP;
          end else begin
            // Beats arrive in line order; the requested word is kept aside for the reply.
            wr_en = 1'b1;
            if (cnt_q == word) ret_d = mem.inst_rdata;
            cnt_d = cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
              set_valid = 1'b1;
              state_d   = ST_RESP;
            end
          end
        end
      end
      ST_RESP: begin
        cpu.cpu_data_ok = 1'b1;
        state_d         = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      ret_q   <= ret_d;
    end
  end

endmodule

// File: tb/tb_icache_direct.sv
// tb/tb_icache_direct.sv - directed self-checking bench for icache_direct
module tb_icache_direct;

  logic clk;
  logic resetn;
  logic flush;
  int   n_tests;
  int   n_fail;

  icache_cpu_if cpu_bus ();
  icache_mem_if mem_bus ();

  icache_direct #(
    .INDEX_W     (6),
    .UNCACHED_EN (1'b1)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .cpu    (cpu_bus),
    .mem    (mem_bus),
    .flush  (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic next();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Full miss transaction starting from IDLE; stall adds rdy delay and gaps between beats.
  task automatic miss_fetch(input string tag, input logic [31:0] a, input logic [31:0] ea,
                            input logic [2:0] es, input logic [31:0] b0, input logic [31:0] b1,
                            input logic [31:0] b2, input logic [31:0] b3, input logic [31:0] er,
                            input int stall, input int flush_beat);
    logic [31:0] b [4];
    int nb;
    b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3;
    nb = (es == 3'b100) ? 4 : 1;
    cpu_bus.cpu_req = 1'b1; cpu_bus.cpu_addr = a; #1;
    check({tag, " idle addr_ok"}, {31'd0, cpu_bus.cpu_addr_ok}, 32'd1);
    next();
    cpu_bus.cpu_req = 1'b0; #1;
    check({tag, " lookup data_ok"}, {31'd0, cpu_bus.cpu_data_ok}, 32'd0);
    check({tag, " lookup addr_ok"}, {31'd0, cpu_bus.cpu_addr_ok}, 32'd0);
    next();
    for (int i = 0; i < stall; i++) begin
      mem_bus.inst_rdy = 1'b0; #1;
      check({tag, " stall req"},  {31'd0, mem_bus.inst_req}, 32'd1);
      check({tag, " stall addr"}, mem_bus.inst_addr, ea);
      check({tag, " stall size"}, {29'd0, mem_bus.inst_size}, {29'd0, es});
      next();
    end
    mem_bus.inst_rdy = 1'b1; #1;
    check({tag, " inst_req"},  {31'd0, mem_bus.inst_req}, 32'd1);
    check({tag, " inst_addr"}, mem_bus.inst_addr, ea);
    check({tag, " inst_size"}, {29'd0, mem_bus.inst_size}, {29'd0, es});
    next();
    mem_bus.inst_rdy = 1'b0;
    for (int i = 0; i < nb; i++) begin
      if (stall > 0) begin
        mem_bus.inst_valid = 1'b0; #1;
        check({tag, " gap data_ok"}, {31'd0, cpu_bus.cpu_data_ok}, 32'd0);
        next();
      end
      mem_bus.inst_valid = 1'b1;
      mem_bus.inst_rdata = b[i];
      mem_bus.inst_last  = (i == nb - 1);
      flush = (i == flush_beat); #1;
      check({tag, " beat data_ok"}, {31'd0, cpu_bus.cpu_data_ok}, 32'd0);
      check({tag, " beat req"},     {31'd0, mem_bus.inst_req}, 32'd0);
      next();
      flush = 1'b0;
    end
    mem_bus.inst_valid = 1'b0; mem_bus.inst_last = 1'b0; #1;
    check({tag, " resp data_ok"}, {31'd0, cpu_bus.cpu_data_ok}, 32'd1);
    check({tag, " resp rdata"},   cpu_bus.cpu_rdata, er);
    check({tag, " resp addr_ok"}, {31'd0, cpu_bus.cpu_addr_ok}, 32'd0);
    next();
    #1;
    check({tag, " back idle"},    {31'd0, cpu_bus.cpu_addr_ok}, 32'd1);
    check({tag, " no 2nd data"},  {31'd0, cpu_bus.cpu_data_ok}, 32'd0);
  endtask

  task automatic hit_fetch(input string tag, input logic [31:0] a, input logic [31:0] er);
    cpu_bus.cpu_req = 1'b1; cpu_bus.cpu_addr = a; #1;
    next();
    cpu_bus.cpu_req = 1'b0; #1;
    check({tag, " hit data_ok"}, {31'd0, cpu_bus.cpu_data_ok}, 32'd1);
    check({tag, " hit rdata"},   cpu_bus.cpu_rdata, er);
    check({tag, " hit addr_ok"}, {31'd0, cpu_bus.cpu_addr_ok}, 32'd1);
    check({tag, " hit no req"},  {31'd0, mem_bus.inst_req}, 32'd0);
    next();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    resetn  = 1'b0;
    flush   = 1'b0;
    cpu_bus.cpu_req    = 1'b0;
    cpu_bus.cpu_addr   = '0;
    mem_bus.inst_rdy   = 1'b0;
    mem_bus.inst_valid = 1'b0;
    mem_bus.inst_last  = 1'b0;
    mem_bus.inst_rdata = '0;
    next(); next(); #1;
    check("reset addr_ok",  {31'd0, cpu_bus.cpu_addr_ok}, 32'd1);
    check("reset data_ok",  {31'd0, cpu_bus.cpu_data_ok}, 32'd0);
    check("reset inst_req", {31'd0, mem_bus.inst_req}, 32'd0);
    resetn = 1'b1;

    // Cold miss on line 0
    miss_fetch("t1", 32'h1FC0_0008, 32'h1FC0_0000, 3'b100,
               32'hA000_0000, 32'hA000_0001, 32'hA000_0002, 32'hA000_0003,
               32'hA000_0002, 0, -1);

    // Stray inst_valid while idle must not touch the arrays
    mem_bus.inst_valid = 1'b1; mem_bus.inst_rdata = 32'hDEAD_BEEF; #1;
    next();
    mem_bus.inst_valid = 1'b0;

    // Back-to-back hits
    cpu_bus.cpu_req = 1'b1; cpu_bus.cpu_addr = 32'h1FC0_0000; #1;
    next();
    cpu_bus.cpu_addr = 32'h1FC0_0004; #1;
    check("t2 hit0 data_ok", {31'd0, cpu_bus.cpu_data_ok}, 32'd1);
    check("t2 hit0 rdata",   cpu_bus.cpu_rdata, 32'hA000_0000);
    next();
    cpu_bus.cpu_addr = 32'h1FC0_000C; #1;
    check("t2 hit1 data_ok", {31'd0, cpu_bus.cpu_data_ok}, 32'd1);
    check("t2 hit1 rdata",   cpu_bus.cpu_rdata, 32'hA000_0001);
    next();
    cpu_bus.cpu_req = 1'b0; #1;
    check("t2 hit3 data_ok", {31'd0, cpu_bus.cpu_data_ok}, 32'd1);
    check("t2 hit3 rdata",   cpu_bus.cpu_rdata, 32'hA000_0003);
    check("t2 no inst_req",  {31'd0, mem_bus.inst_req}, 32'd0);
    next();

    // Conflict on index 0, then the old tag misses again
    miss_fetch("t3a", 32'h1FC0_0408, 32'h1FC0_0400, 3'b100,
               32'hB000_0000, 32'hB000_0001, 32'hB000_0002, 32'hB000_0003,
               32'hB000_0002, 0, -1);
    miss_fetch("t3b", 32'h1FC0_0008, 32'h1FC0_0000, 3'b100,
               32'hC000_0000, 32'hC000_0001, 32'hC000_0002, 32'hC000_0003,
               32'hC000_0002, 0, -1);

    // Uncached fetch, twice, never allocates
    miss_fetch("t4a", 32'hBFC0_0010, 32'hBFC0_0010, 3'b010,
               32'h5500_0000, 32'h0, 32'h0, 32'h0, 32'h5500_0000, 0, -1);
    miss_fetch("t4b", 32'hBFC0_0010, 32'hBFC0_0010, 3'b010,
               32'h5500_0001, 32'h0, 32'h0, 32'h0, 32'h5500_0001, 0, -1);

    // Flush mid-refill of line 0 keeps line 0, drops line 1
    miss_fetch("t5a", 32'h1FC0_0010, 32'h1FC0_0010, 3'b100,
               32'hD000_0000, 32'hD000_0001, 32'hD000_0002, 32'hD000_0003,
               32'hD000_0000, 0, -1);
    miss_fetch("t5b", 32'h1FC0_0404, 32'h1FC0_0400, 3'b100,
               32'hE000_0000, 32'hE000_0001, 32'hE000_0002, 32'hE000_0003,
               32'hE000_0001, 0, 1);
    hit_fetch("t5c", 32'h1FC0_040C, 32'hE000_0003);
    miss_fetch("t5d", 32'h1FC0_0010, 32'h1FC0_0010, 3'b100,
               32'hF000_0000, 32'hF000_0001, 32'hF000_0002, 32'hF000_0003,
               32'hF000_0000, 0, -1);
    hit_fetch("t5e", 32'h1FC0_0400, 32'hE000_0000);
    flush = 1'b1; #1;
    next();
    flush = 1'b0;
    miss_fetch("t5f", 32'h1FC0_0400, 32'h1FC0_0400, 3'b100,
               32'h6000_0000, 32'h6000_0001, 32'h6000_0002, 32'h6000_0003,
               32'h6000_0000, 0, -1);

    // Stalled arbitration and gapped beats
    miss_fetch("t6a", 32'h1FC0_0024, 32'h1FC0_0020, 3'b100,
               32'h7000_0000, 32'h7000_0001, 32'h7000_0002, 32'h7000_0003,
               32'h7000_0001, 10, -1);

    // Reset in the middle of a refill
    cpu_bus.cpu_req = 1'b1; cpu_bus.cpu_addr = 32'h1FC0_0030; #1;
    next();
    cpu_bus.cpu_req = 1'b0;
    next();
    mem_bus.inst_rdy = 1'b1; #1;
    check("t6b inst_addr", mem_bus.inst_addr, 32'h1FC0_0030);
    next();
    mem_bus.inst_rdy = 1'b0;
    mem_bus.inst_valid = 1'b1; mem_bus.inst_rdata = 32'h8000_0000;
    next();
    mem_bus.inst_valid = 1'b0;
    resetn = 1'b0;
    next();
    resetn = 1'b1; #1;
    check("t6b rst addr_ok",  {31'd0, cpu_bus.cpu_addr_ok}, 32'd1);
    check("t6b rst data_ok",  {31'd0, cpu_bus.cpu_data_ok}, 32'd0);
    check("t6b rst inst_req", {31'd0, mem_bus.inst_req}, 32'd0);
    miss_fetch("t6c", 32'h1FC0_0024, 32'h1FC0_0020, 3'b100,
               32'h9000_0000, 32'h9000_0001, 32'h9000_0002, 32'h9000_0003,
               32'h9000_0001, 0, -1);
    miss_fetch("t6d", 32'h1FC0_0400, 32'h1FC0_0400, 3'b100,
               32'h9100_0000, 32'h9100_0001, 32'h9100_0002, 32'h9100_0003,
               32'h9100_0000, 0, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
